// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Provides the divisor floor, the FSM state type and the divisor clamp.
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    function automatic int clamp_div(input int n);
        return (n < DIV_MIN) ? DIV_MIN : n;
    endfunction

endpackage

// File: rtl/clk_div_outstage.sv
// Output path of the divider: negedge-shifted phase and parity OR.
// Ports: clk, rst_n (async low), clk_p (posedge phase), odd (N parity),
//        o_clk (divided clock).
module clk_div_outstage (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_p,
    input  logic odd,
    output logic o_clk
);

    logic clk_n;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n <= 1'b0;
        end else begin
            clk_n <= clk_p;
        end
    end

    // Odd N stretches the high phase by half an input period.
    assign o_clk = clk_p | (odd & clk_n);

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for even and odd N.
// Ports: clk, rst_n (async low), en (run request), div_val/div_load (new N),
//        busy (load pending), active, o_tick (period start), o_clk.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             busy,
    output logic             active,
    output logic             o_tick,
    output logic             o_clk
);

    localparam logic [WIDTH-1:0] N_RST = WIDTH'(clamp_div(DEF_DIV));

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_pend;
    logic [WIDTH-1:0] half;
    logic             clk_p;
    logic             wrap;
    logic             start;
    logic             apply;

    assign wrap   = (state != IDLE) && (cnt == n_act - WIDTH'(1));
    assign start  = (state == IDLE) && en;
    // Pending divisors only take effect on a period boundary.
    assign apply  = busy && (wrap || start);
    assign cnt_nx = wrap ? '0 : cnt + WIDTH'(1);
    assign half   = n_act >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            clk_p  <= 1'b0;
            o_tick <= 1'b0;
            active <= 1'b0;
            busy   <= 1'b0;
            n_act  <= N_RST;
            n_pend <= N_RST;
        end else begin
            o_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state  <= RUN;
                        cnt    <= '0;
                        clk_p  <= 1'b1;
                        o_tick <= 1'b1;
                        active <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    // A stop request is honoured only once the period ends.
                    if (wrap && state == STOP && !en) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        clk_p  <= 1'b0;
                        active <= 1'b0;
                    end else begin
                        state <= en ? RUN : STOP;
                        cnt   <= cnt_nx;
                        if (wrap) begin
                            clk_p  <= 1'b1;
                            o_tick <= 1'b1;
                        end else if (cnt_nx == half) begin
                            clk_p <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (apply) begin
                n_act <= n_pend;
                busy  <= 1'b0;
            end
            // A load on a boundary edge stays pending for the next one.
            if (div_load) begin
                n_pend <= WIDTH'(clamp_div(int'(div_val)));
                busy   <= 1'b1;
            end
        end
    end

    clk_div_outstage u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .clk_p (clk_p),
        .odd   (n_act[0]),
        .o_clk (o_clk)
    );

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog against a half-cycle waveform model.
// Ports: none; drives clk, rst_n, en, div_val, div_load.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       busy;
    logic       active;
    logic       o_tick;
    logic       o_clk;

    int errors = 0;
    int checks = 0;

    // Model: a period of N input clocks is 2N half-cycles, o_clk high for
    // the first N of them; m_pos is the input-clock index inside the period.
    int m_n, m_pend, m_pos;
    bit m_run, m_stop, m_busy;

    logic [3:0] got_p, exp_p;
    logic       got_n, exp_n;

    always #5 clk = ~clk;

    clk_div_prog #(.WIDTH(8), .DEF_DIV(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .busy     (busy),
        .active   (active),
        .o_tick   (o_tick),
        .o_clk    (o_clk)
    );

    function automatic int clampm(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_n = 3; m_pend = 3; m_pos = 0;
        m_run = 0; m_stop = 0; m_busy = 0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int v);
        if (m_run) begin
            if (m_pos + 1 == m_n) begin
                if (m_busy) begin m_n = m_pend; m_busy = 0; end
                if (m_stop && !e) m_run = 0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            m_stop = m_run && !e;
        end else if (e) begin
            if (m_busy) begin m_n = m_pend; m_busy = 0; end
            m_run = 1; m_pos = 0; m_stop = 0;
        end
        if (ld) begin m_pend = clampm(v); m_busy = 1; end
    endtask

    task automatic step();
        bit e, ld;
        int v;
        e = en; ld = div_load; v = int'(div_val);
        @(posedge clk);
        model_edge(e, ld, v);
        #1;
        got_p = {o_clk, o_tick, active, busy};
        exp_p = {m_run && (2 * m_pos < m_n), m_run && m_pos == 0, m_run, m_busy};
        @(negedge clk);
        #1;
        got_n = o_clk;
        exp_n = m_run && (2 * m_pos + 1 < m_n);
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; div_load = 0;
        #12;
        checks++;
        if ({o_clk, o_tick, active, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=0000", {o_clk, o_tick, active, busy});
        end
        @(negedge clk); #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL reset_idle pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL reset_idle neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_def_div();
        en = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL def_div pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL def_div neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_load_apply();
        bit done = 0;
        for (int i = 0; i < 16; i++) begin
            div_load = !done && m_pos == 1 && m_n == 3;
            div_val = 8'd4;
            if (div_load) done = 1;
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL load_apply pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL load_apply neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL load_apply_sched got=0 exp=1"); end
    endtask

    task automatic test_last_wins();
        bit l5 = 0, l7 = 0;
        for (int i = 0; i < 30; i++) begin
            div_load = 0;
            if (!l5 && m_pos == 0) begin div_load = 1; div_val = 8'd5; l5 = 1; end
            else if (l5 && !l7 && m_pos == 1) begin div_load = 1; div_val = 8'd7; l7 = 1; end
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL last_wins pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL last_wins neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 28; i++) begin
            div_load = (i == 0) || (i == 14);
            div_val = (i == 0) ? 8'd0 : 8'd1;
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL clamp pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL clamp neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_stop(input bit resume);
        bit dropped = 0, back = 0;
        int at = 0;
        en = 1;
        for (int i = 0; i < 40; i++) begin
            div_load = (i == 0);
            div_val = 8'd6;
            if (!dropped && m_run && m_n == 6 && m_pos == 1) begin
                en = 0; dropped = 1; at = i;
            end else if (dropped && !back && resume && m_pos == 3) begin
                en = 1; back = 1;
            end else if (dropped && !back && i == at + 10) begin
                en = 1; back = 1;
            end
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL stop%0d pos cyc=%0d got=%b exp=%b", resume, i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL stop%0d neg cyc=%0d got=%b exp=%b", resume, i, got_n, exp_n); end
        end
        checks++;
        if (!back) begin errors++; $display("FAIL stop%0d_sched got=0 exp=1", resume); end
    endtask

    task automatic test_max();
        en = 1;
        for (int i = 0; i < 530; i++) begin
            div_load = (i == 0);
            div_val = 8'd255;
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL max pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL max neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            div_load = ($urandom_range(0, 5) == 0);
            div_val = 8'($urandom_range(0, 12));
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL random pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL random neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    task automatic test_reset_mid();
        bit l9 = 0;
        en = 1;
        for (int i = 0; i < 40 && !l9; i++) begin
            div_load = (i == 0);
            div_val = 8'd5;
            if (i > 0 && m_run && m_n == 5 && m_pos == 0) begin
                div_load = 1; div_val = 8'd9; l9 = 1;
            end
            step();
            div_load = 0;
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL rst_mid pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL rst_mid neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
        checks++;
        if ({l9, o_clk, busy} !== 3'b111) begin
            errors++;
            $display("FAIL rst_mid_pre got=%b exp=111", {l9, o_clk, busy});
        end
        rst_n = 0;
        #1;
        checks++;
        if ({o_clk, o_tick, active, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_async got=%b exp=0000", {o_clk, o_tick, active, busy});
        end
        #2;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (got_p !== exp_p) begin errors++; $display("FAIL rst_post pos cyc=%0d got=%b exp=%b", i, got_p, exp_p); end
            checks++;
            if (got_n !== exp_n) begin errors++; $display("FAIL rst_post neg cyc=%0d got=%b exp=%b", i, got_n, exp_n); end
        end
    endtask

    initial begin
        test_reset();
        test_def_div();
        test_load_apply();
        test_last_wins();
        test_clamp();
        test_stop(1'b0);
        test_stop(1'b1);
        test_max();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
